pokey_serin: RTL and testbench

POKEY_SERIN -- requirements
Module: pokey_serin

---
 rtl/pokey_serin.sv | 199 +++++++++++++++++++
 tb/tb_pokey_serin.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pokey_serin.sv
// ============================================================================
// Module   : pokey_serin
// Brief    : POKEY-style asynchronous serial receiver (8N1, LSB first), timed
//            by the 1.79 MHz enp strobe, with SERIN/SKSTAT-like status flags.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pokey_serin #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enp,
  input  logic        sid,
  input  logic [15:0] baud_div,
  input  logic        rd_ack,
  input  logic        err_clr,
  output logic [7:0]  serin,
  output logic        rx_ready,
  output logic        rx_irq,
  output logic        overrun,
  output logic        frame_err,
  output logic        rx_busy
);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BREAK = 3'd4;

  localparam logic [15:0] C_MIN_PERIOD = 16'd2;

  generate
    if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync_stages
      $error("pokey_serin: SYNC_STAGES must be 2 or 3");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  serin_q, serin_d;
  logic        rx_ready_q, rx_ready_d;
  logic        rx_irq_q, rx_irq_d;
  logic        overrun_q, overrun_d;
  logic        frame_err_q, frame_err_d;

  logic        sid_s;
  logic [15:0] period;
  logic [15:0] half_period;
  logic        sample;
  logic        done;

  // Synchronizer shifts toward the MSB; the MSB is the only stage used.
  assign sync_d = {sync_q[SYNC_STAGES-2:0], sid};
  assign sid_s  = sync_q[SYNC_STAGES-1];

  assign period      = (baud_div < C_MIN_PERIOD) ? C_MIN_PERIOD : baud_div;
  assign half_period = period >> 1;

  // The counter is loaded with a non-zero value, so the sample point is the
  // enp tick on which it steps from 1 down to 0.
  assign sample = enp && (cnt_q <= 16'd1);

  // State register and all other flops.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q      <= '1;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      serin_q     <= '0;
      rx_ready_q  <= 1'b0;
      rx_irq_q    <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      serin_q     <= serin_d;
      rx_ready_q  <= rx_ready_d;
      rx_irq_q    <= rx_irq_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // Next-state and bit-timing logic; everything holds while enp is low.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    done      = 1'b0;
    if (enp) begin
      case (state_q)
        ST_IDLE: begin
          if (!sid_s) begin
            state_d = ST_START;
            cnt_d   = half_period;
          end
        end
        ST_START: begin
          if (sample) begin
            if (sid_s) begin
              state_d = ST_IDLE;
              cnt_d   = '0;
            end else begin
              state_d   = ST_DATA;
              bit_idx_d = '0;
              cnt_d     = period;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (sample) begin
            shift_d = {sid_s, shift_q[7:1]};
            cnt_d   = period;
            if (bit_idx_q == 3'd7) begin
              state_d = ST_STOP;
            end else begin
              bit_idx_d = bit_idx_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (sample) begin
            done    = 1'b1;
            cnt_d   = '0;
            state_d = sid_s ? ST_IDLE : ST_BREAK;
          end else begin
            cnt_d = cnt_q - 16'd1;
          end
        end
        ST_BREAK: begin
          if (sid_s) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Status flags: a completing frame takes priority over read/clear strobes.
  always_comb begin
    serin_d     = done ? shift_q : serin_q;
    rx_irq_d    = done;
    rx_ready_d  = rx_ready_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;

    if (done) begin
      rx_ready_d = 1'b1;
    end else if (rd_ack) begin
      rx_ready_d = 1'b0;
    end

    if (done && rx_ready_q && !rd_ack) begin
      overrun_d = 1'b1;
    end else if (err_clr) begin
      overrun_d = 1'b0;
    end

    if (done && !sid_s) begin
      frame_err_d = 1'b1;
    end else if (err_clr) begin
      frame_err_d = 1'b0;
    end
  end

  // Output decode.
  always_comb begin
    serin     = serin_q;
    rx_ready  = rx_ready_q;
    rx_irq    = rx_irq_q;
    overrun   = overrun_q;
    frame_err = frame_err_q;
    rx_busy   = (state_q != ST_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_pokey_serin.sv
// ============================================================================
// Module   : tb_pokey_serin
// Brief    : Self-checking bench for pokey_serin: vector table of frames plus
//            hand-written glitch, break, reset and read-collision sequences.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pokey_serin;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enp = 1'b0;
  logic        sid = 1'b1;
  logic [15:0] baud_div = 16'd16;
  logic        rd_ack;
  logic        rd_ack_man = 1'b0;
  logic        rd_ack_sync = 1'b0;
  logic        err_clr = 1'b0;
  logic [7:0]  serin;
  logic        rx_ready, rx_irq, overrun, frame_err, rx_busy;

  pokey_serin #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .enp(enp), .sid(sid), .baud_div(baud_div),
    .rd_ack(rd_ack), .err_clr(err_clr), .serin(serin), .rx_ready(rx_ready),
    .rx_irq(rx_irq), .overrun(overrun), .frame_err(frame_err), .rx_busy(rx_busy)
  );

  always #10 clk = ~clk;

  assign rd_ack = rd_ack_man | rd_ack_sync;

  // enp: one clk high out of every 8; an armed rd_ack fires on the next enp.
  int div = 0;
  bit ack_arm = 1'b0;
  always @(negedge clk) begin
    div = (div == 7) ? 0 : div + 1;
    enp = (div == 0);
    rd_ack_sync = enp & ack_arm;
    if (rd_ack_sync) ack_arm = 1'b0;
  end

  typedef struct {
    logic [7:0] serin;
    logic       ready;
    logic       ovr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [7:0]  data;
    logic [15:0] baud;
    logic        post_clr;
    logic        post_ack;
    logic        ovr_exp;
    logic        ready_after;
    logic        ovr_after;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int total = 0;
  int bad = 0;
  int irq_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Scoreboard consumer: each rx_irq pops one expected frame.
  always @(negedge clk) begin
    if (!reset && rx_irq === 1'b1) begin
      irq_cnt++;
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_irq: got irq with serin=%0h want none", serin);
      end else begin
        mon_e = sb.pop_front();
        chk("sb_serin", serin, mon_e.serin);
        chk("sb_ready", rx_ready, mon_e.ready);
        chk("sb_overrun", overrun, mon_e.ovr);
        chk("sb_frame_err", frame_err, mon_e.ferr);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      do @(posedge clk); while (enp !== 1'b1);
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb, input int p, input bit arm);
    int half;
    half = p / 2;
    sid = 1'b0;
    tick(p);
    for (int i = 0; i < 8; i++) begin
      sid = d[i];
      tick(p);
    end
    sid = stopb;
    tick(half);
    if (arm) ack_arm = 1'b1;
    tick(p - half);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL %s: got %0d frames without irq want 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic pulse_ack();
    rd_ack_man = 1'b1;
    @(negedge clk);
    rd_ack_man = 1'b0;
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_serin"}, serin, 8'h00);
    chk({tag, "_ready"}, rx_ready, 1'b0);
    chk({tag, "_irq"}, rx_irq, 1'b0);
    chk({tag, "_overrun"}, overrun, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_busy"}, rx_busy, 1'b0);
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    int pe;
    int irq_base;

    vecs[0] = '{8'hA5, 16'd16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1] = '{8'h3C, 16'd16, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h5A, 16'd5,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'hC3, 16'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{8'h81, 16'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("reset");
    tick(2);

    for (int i = 0; i < 5; i++) begin
      baud_div = vecs[i].baud;
      pe = (vecs[i].baud < 16'd2) ? 2 : int'(vecs[i].baud);
      sb.push_back('{vecs[i].data, 1'b1, vecs[i].ovr_exp, 1'b0});
      send_frame(vecs[i].data, 1'b1, pe, 1'b0);
      tick(2);
      wait_drain("vec_drain");
      chk("vec_irq_count", irq_cnt, i + 1);
      if (vecs[i].post_clr) pulse_clr();
      if (vecs[i].post_ack) pulse_ack();
      @(negedge clk);
      chk("vec_overrun_after", overrun, vecs[i].ovr_after);
      chk("vec_ready_after", rx_ready, vecs[i].ready_after);
      chk("vec_frame_err_after", frame_err, 1'b0);
    end

    // Short low pulse: start bit rejected at its mid-point.
    baud_div = 16'd16;
    irq_base = irq_cnt;
    sid = 1'b0;
    tick(4);
    chk("glitch_busy_during", rx_busy, 1'b1);
    sid = 1'b1;
    tick(12);
    chk("glitch_busy_after", rx_busy, 1'b0);
    chk("glitch_irq", irq_cnt, irq_base);
    chk("glitch_flags", {rx_ready, overrun, frame_err}, 3'b000);

    // Framing error followed by a held-low line.
    irq_base = irq_cnt;
    sb.push_back('{8'h00, 1'b1, 1'b0, 1'b1});
    send_frame(8'h00, 1'b0, 16, 1'b0);
    tick(40);
    wait_drain("break_drain");
    chk("break_busy", rx_busy, 1'b1);
    chk("break_irq", irq_cnt, irq_base + 1);
    chk("break_frame_err", frame_err, 1'b1);
    chk("break_serin", serin, 8'h00);
    sid = 1'b1;
    tick(3);
    chk("break_exit_busy", rx_busy, 1'b0);
    chk("break_exit_irq", irq_cnt, irq_base + 1);
    pulse_clr();
    pulse_ack();
    @(negedge clk);
    chk("break_clr_ferr", frame_err, 1'b0);

    // Load a byte so reset has something to clear, then abort mid-frame.
    sb.push_back('{8'hE7, 1'b1, 1'b0, 1'b0});
    send_frame(8'hE7, 1'b1, 16, 1'b0);
    tick(2);
    wait_drain("pre_reset_drain");
    sid = 1'b0; tick(16);
    sid = 1'b1; tick(16);
    sid = 1'b0; tick(16);
    sid = 1'b1; tick(10);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_idle_outputs("midreset");
    tick(2);
    irq_base = irq_cnt;
    sb.push_back('{8'h5A, 1'b1, 1'b0, 1'b0});
    send_frame(8'h5A, 1'b1, 16, 1'b0);
    tick(2);
    wait_drain("post_reset_drain");
    chk("post_reset_irq", irq_cnt, irq_base + 1);

    // rd_ack lands exactly on the completion cycle of a second byte.
    sb.push_back('{8'h96, 1'b1, 1'b0, 1'b0});
    send_frame(8'h96, 1'b1, 16, 1'b1);
    tick(2);
    wait_drain("collide_drain");
    chk("collide_ready", rx_ready, 1'b1);
    chk("collide_overrun", overrun, 1'b0);
    chk("collide_irq", irq_cnt, irq_base + 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
